inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of instruction decode (Control, Registers, Sign_Extend consume its output).
- Owns the fetch PC, drives the combinational Instruction_Memory, and buffers fetched words in a small FIFO.
- Hands {pc, instruction} pairs to decode over a valid/ready handshake; supports stall (ready low) and redirect/flush (branch or jump).

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; low 2 bits must be 0.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  fetch enable; when low, no new fetches are issued.
- imem_addr_o  out  32  fetch address to Instruction_Memory; equals the fetch PC register.
- imem_req_o  out  1  a fetch is accepted this cycle.
- imem_data_i  in  32  instruction word for imem_addr_o, valid in the same cycle (combinational memory).
- redirect_i  in  1  flush the queue and restart fetch.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- inst_o  out  32  head instruction.
- pc_o  out  32  PC of the head instruction.
- valid_o  out  1  head entry is valid.
- ready_i  in  1  decode accepts the head this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_i=1 at a clock edge): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0. After the edge: valid_o=0, count_o=0, imem_req_o=0, imem_addr_o=RESET_PC. inst_o and pc_o are don't-care while valid_o=0. Reset overrides every other input.
- pop = valid_o & ready_i. valid_o = (count!=0).
- space = (count<DEPTH) | pop. Pushing into a full FIFO is allowed in the same cycle as a pop.
- imem_req_o = start_i & space & ~redirect_i & ~rst_i.
- Push (imem_req_o=1) writes {imem_addr_o, imem_data_i} at wr_ptr; wr_ptr+=1; fetch_pc+=4.
- fetch_pc wraps modulo 2^32. Pointers wrap modulo DEPTH.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Latency: a word fetched in cycle N appears on inst_o/valid_o in cycle N+1 at the earliest.
- Stall: with ready_i=0, entries and head outputs stay stable. Fetch continues until count=DEPTH, then fetch_pc holds.
- start_i=0: no pushes and fetch_pc holds; pops continue normally.
- Redirect (redirect_i=1, rst_i=0):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc_i[31:2],2'b00}.
  - No push occurs in the redirect cycle.
  - A handshake (valid_o & ready_i) in the redirect cycle still counts as consumed.
  - Back-to-back redirects: the last one wins.
  - Redirect while start_i=0 still loads fetch_pc and flushes.
- No combinational path from ready_i to imem_addr_o. imem_req_o may depend combinationally on ready_i, redirect_i and start_i.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when count=0, start_i=1 and redirect_i=0, the word fetched this cycle is driven straight through:
  - valid_o=1, inst_o=imem_data_i, pc_o=imem_addr_o in the same cycle.
  - If ready_i=1, the word is consumed and not written to the FIFO (zero-latency path); otherwise it is pushed normally.
- Not defined: valid_o is purely registered-state based and minimum fetch-to-decode latency is 1 cycle, as above.

Test Plan:
- Reset, then start_i=1, ready_i=1, memory returns addr^32'hA5A5_0000:
  - Cycle 1 after reset: valid_o=1, pc_o=0, inst_o=32'hA5A5_0000.
  - Subsequent cycles: pc_o=4, 8, 12… with one instruction per cycle.
- ready_i=0 from reset with DEPTH=4:
  - After 4 fetches: count_o=4, imem_req_o=0, imem_addr_o=16, head pc_o=0 held.
  - Raise ready_i: pushes and pops occur in the same cycle, count_o stays 4.
- With count_o=3, assert redirect_i with redirect_pc_i=32'h0000_0107:
  - Next cycle: count_o=0, valid_o=0, imem_addr_o=32'h0000_0104.
  - Following cycle: pc_o=32'h104.
- Drop start_i for 3 cycles with ready_i=1: queue drains to count_o=0 and imem_addr_o holds. Re-raise start_i: fetch resumes at the held address with no skipped PC.
- RESET_PC=32'hFFFF_FFF8, start_i=1: fetched PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap-around).
- Assert rst_i mid-stream with count_o=2 and redirect_i=1 in the same cycle: after the edge count_o=0, valid_o=0, imem_addr_o=RESET_PC (reset beats redirect).

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if
//   Bundles every non-clock, non-reset signal of the instruction-fetch queue:
//   fetch control (start_i, redirect_i, redirect_pc_i), the combinational
//   instruction-memory port (imem_addr_o, imem_req_o, imem_data_i) and the
//   decode-side valid/ready handshake (inst_o, pc_o, valid_o, ready_i,
//   count_o).
//   Signal suffixes are named from the fetch queue's point of view.
//   modport master : the fetch queue itself.
//   modport slave  : the surrounding environment (memory, decode, control).
interface inst_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          start_i;
  logic [31:0]   imem_addr_o;
  logic          imem_req_o;
  logic [31:0]   imem_data_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic [31:0]   inst_o;
  logic [31:0]   pc_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;

  modport master (
    input  start_i, imem_data_i, redirect_i, redirect_pc_i, ready_i,
    output imem_addr_o, imem_req_o, inst_o, pc_o, valid_o, count_o
  );

  modport slave (
    output start_i, imem_data_i, redirect_i, redirect_pc_i, ready_i,
    input  imem_addr_o, imem_req_o, inst_o, pc_o, valid_o, count_o
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction-fetch front end feeding decode. Owns the fetch PC, drives a
//   combinational instruction memory and buffers {pc, instruction} pairs in a
//   DEPTH-entry FIFO that decode drains over a valid/ready handshake.
//   A redirect flushes the FIFO and restarts fetch at a word-aligned PC.
//
// Ports
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : synchronous active-high reset, overrides every other input
//   fq     : inst_fetch_queue_if.master (fetch control, imem port, decode
//            handshake, occupancy)
//
// Parameters
//   DEPTH    : FIFO entries, power of two, at least 2
//   RESET_PC : fetch PC loaded on reset, word aligned
//
// Optional feature
//   FETCH_BYPASS_EN : when defined and the FIFO is empty, the word being
//   fetched is presented to decode in the same cycle; if decode takes it, it
//   is never written into the FIFO.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  inst_fetch_queue_if.master fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [31:0]   inst_mem_r [DEPTH];

  logic bypass_s;
  logic valid_s;
  logic pop_s;
  logic space_s;
  logic req_s;
  logic push_fifo_s;
  logic pop_fifo_s;

  // Handshake, space and fetch-request decode plus head-entry output muxing.
  always_comb begin
    bypass_s = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass_s = (count_r == {CW{1'b0}}) & fq.start_i & ~fq.redirect_i & ~rst_i;
`endif
    valid_s = (count_r != {CW{1'b0}}) | bypass_s;
    pop_s   = valid_s & fq.ready_i;
    // A full FIFO still has room when its head leaves this cycle.
    space_s = (count_r < DEPTH_C) | pop_s;
    req_s   = fq.start_i & space_s & ~fq.redirect_i & ~rst_i;
    // A bypassed word that decode accepts never touches the storage.
    push_fifo_s = req_s & ~(bypass_s & fq.ready_i);
    pop_fifo_s  = pop_s & ~bypass_s;

    fq.valid_o     = valid_s;
    fq.imem_req_o  = req_s;
    fq.imem_addr_o = fetch_pc_r;
    fq.count_o     = count_r;
    if (bypass_s) begin
      fq.inst_o = fq.imem_data_i;
      fq.pc_o   = fetch_pc_r;
    end else begin
      fq.inst_o = inst_mem_r[rd_ptr_r];
      fq.pc_o   = pc_mem_r[rd_ptr_r];
    end
  end

  // Fetch PC, pointers and occupancy; reset beats redirect beats normal flow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_r <= RESET_PC;
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else if (fq.redirect_i) begin
      fetch_pc_r <= {fq.redirect_pc_i[31:2], 2'b00};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (req_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push_fifo_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_fifo_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_fifo_s, pop_fifo_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_fifo_s) begin
      pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
      inst_mem_r[wr_ptr_r] <= fq.imem_data_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC2_C = 32'hFFFF_FFF8;
  localparam logic [31:0] XOR_C       = 32'hA5A5_0000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic rst2  = 1'b1;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) fq  ();
  inst_fetch_queue_if #(.DEPTH(DEPTH)) fq2 ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC_C)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .fq    (fq.master)
  );

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC2_C)) dut_wrap (
    .clk_i (clk_i),
    .rst_i (rst2),
    .fq    (fq2.master)
  );

  // Combinational instruction memory model.
  assign fq.imem_data_i  = fq.imem_addr_o ^ XOR_C;
  assign fq2.imem_data_i = fq2.imem_addr_o ^ XOR_C;

  // Scoreboard monitor on the main DUT, evaluated mid-cycle.
  logic [63:0]   sb_q [$];
  logic [63:0]   sb_head;
  logic [31:0]   model_pc;
  logic [CW-1:0] exp_cnt;
  logic          exp_valid;
  logic          exp_req;
  int            sz;

  always @(negedge clk_i) begin
    if (rst_i) begin
      sb_q.delete();
      model_pc = RESET_PC_C;
    end else begin
      sz        = sb_q.size();
      exp_cnt   = sz[CW-1:0];
      exp_valid = (sz != 0);
`ifdef FETCH_BYPASS_EN
      if (sz == 0 && fq.start_i && !fq.redirect_i) exp_valid = 1'b1;
`endif
      exp_req = fq.start_i & ~fq.redirect_i & ((sz < DEPTH) | (exp_valid & fq.ready_i));

      tests_run++;
      if (fq.count_o !== exp_cnt) begin
        fails++;
        $display("FAIL sb_count got %0d want %0d at %0t", fq.count_o, exp_cnt, $time);
      end
      tests_run++;
      if (fq.valid_o !== exp_valid) begin
        fails++;
        $display("FAIL sb_valid got %b want %b at %0t", fq.valid_o, exp_valid, $time);
      end
      tests_run++;
      if (fq.imem_req_o !== exp_req) begin
        fails++;
        $display("FAIL sb_req got %b want %b at %0t", fq.imem_req_o, exp_req, $time);
      end
      if (exp_req) begin
        tests_run++;
        if (fq.imem_addr_o !== model_pc) begin
          fails++;
          $display("FAIL sb_addr got %h want %h at %0t", fq.imem_addr_o, model_pc, $time);
        end
        sb_q.push_back({model_pc, model_pc ^ XOR_C});
        model_pc = model_pc + 32'd4;
      end
      if (fq.valid_o === 1'b1 && fq.ready_i === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow pop with empty model at %0t", $time);
        end else begin
          sb_head = sb_q.pop_front();
          if ({fq.pc_o, fq.inst_o} !== sb_head) begin
            fails++;
            $display("FAIL sb_head got %h/%h want %h/%h at %0t",
                     fq.pc_o, fq.inst_o, sb_head[63:32], sb_head[31:0], $time);
          end
        end
      end
      if (fq.redirect_i) begin
        sb_q.delete();
        model_pc = {fq.redirect_pc_i[31:2], 2'b00};
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    fq.redirect_i = 1'b0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    step();
    #1;
    tests_run++;
    if (fq.valid_o !== 1'b0 || fq.count_o !== 3'd0 || fq.imem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got v=%b c=%0d r=%b want v=0 c=0 r=0",
               fq.valid_o, fq.count_o, fq.imem_req_o);
    end
    tests_run++;
    if (fq.imem_addr_o !== RESET_PC_C) begin
      fails++;
      $display("FAIL reset_addr got %h want %h", fq.imem_addr_o, RESET_PC_C);
    end
  endtask

  task automatic test_stream();
    fq.start_i = 1'b1;
    fq.ready_i = 1'b1;
    do_reset();
    #1;
    tests_run++;
    if (fq.valid_o !== 1'b0) begin
      fails++;
      $display("FAIL stream_first_latency got valid=%b want 0", fq.valid_o);
    end
    step();
    #1;
    tests_run++;
    if (fq.valid_o !== 1'b1 || fq.pc_o !== 32'h0 || fq.inst_o !== 32'hA5A5_0000) begin
      fails++;
      $display("FAIL stream_first got v=%b pc=%h inst=%h want 1/00000000/a5a50000",
               fq.valid_o, fq.pc_o, fq.inst_o);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      #1;
      tests_run++;
      if (fq.pc_o !== 32'(k * 4) || fq.inst_o !== (32'(k * 4) ^ XOR_C)) begin
        fails++;
        $display("FAIL stream_seq got pc=%h want %h", fq.pc_o, 32'(k * 4));
      end
    end
  endtask

  task automatic test_stall();
    fq.start_i = 1'b1;
    fq.ready_i = 1'b0;
    do_reset();
    repeat (4) step();
    #1;
    tests_run++;
    if (fq.count_o !== 3'd4 || fq.imem_req_o !== 1'b0 || fq.imem_addr_o !== 32'd16) begin
      fails++;
      $display("FAIL stall_full got c=%0d r=%b a=%h want 4/0/00000010",
               fq.count_o, fq.imem_req_o, fq.imem_addr_o);
    end
    step();
    #1;
    tests_run++;
    if (fq.pc_o !== 32'h0 || fq.count_o !== 3'd4) begin
      fails++;
      $display("FAIL stall_hold got pc=%h c=%0d want 00000000/4", fq.pc_o, fq.count_o);
    end
    fq.ready_i = 1'b1;
    #1;
    tests_run++;
    if (fq.imem_req_o !== 1'b1) begin
      fails++;
      $display("FAIL stall_full_push got req=%b want 1", fq.imem_req_o);
    end
    step();
    #1;
    tests_run++;
    if (fq.count_o !== 3'd4 || fq.pc_o !== 32'd4) begin
      fails++;
      $display("FAIL stall_release got c=%0d pc=%h want 4/00000004", fq.count_o, fq.pc_o);
    end
  endtask

  task automatic test_redirect();
    fq.start_i = 1'b1;
    fq.ready_i = 1'b0;
    do_reset();
    repeat (3) step();
    fq.redirect_i    = 1'b1;
    fq.redirect_pc_i = 32'h0000_0107;
    fq.ready_i       = 1'b1;
    #1;
    tests_run++;
    if (fq.imem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL redirect_no_push got req=%b want 0", fq.imem_req_o);
    end
    step();
    fq.redirect_i = 1'b0;
    #1;
    tests_run++;
    if (fq.count_o !== 3'd0 || fq.valid_o !== 1'b0 || fq.imem_addr_o !== 32'h0000_0104) begin
      fails++;
      $display("FAIL redirect_flush got c=%0d v=%b a=%h want 0/0/00000104",
               fq.count_o, fq.valid_o, fq.imem_addr_o);
    end
    step();
    #1;
    tests_run++;
    if (fq.valid_o !== 1'b1 || fq.pc_o !== 32'h104 || fq.inst_o !== 32'hA5A5_0104) begin
      fails++;
      $display("FAIL redirect_head got v=%b pc=%h inst=%h want 1/00000104/a5a50104",
               fq.valid_o, fq.pc_o, fq.inst_o);
    end
    fq.redirect_i    = 1'b1;
    fq.redirect_pc_i = 32'h0000_0200;
    step();
    fq.redirect_pc_i = 32'h0000_0303;
    step();
    fq.redirect_i = 1'b0;
    #1;
    tests_run++;
    if (fq.imem_addr_o !== 32'h0000_0300 || fq.count_o !== 3'd0) begin
      fails++;
      $display("FAIL redirect_last_wins got a=%h c=%0d want 00000300/0",
               fq.imem_addr_o, fq.count_o);
    end
  endtask

  task automatic test_start_drop();
    fq.start_i = 1'b1;
    fq.ready_i = 1'b1;
    do_reset();
    repeat (3) step();
    fq.start_i = 1'b0;
    #1;
    tests_run++;
    if (fq.imem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL start_low_req got req=%b want 0", fq.imem_req_o);
    end
    repeat (3) step();
    #1;
    tests_run++;
    if (fq.count_o !== 3'd0 || fq.imem_addr_o !== 32'd12) begin
      fails++;
      $display("FAIL start_drain got c=%0d a=%h want 0/0000000c", fq.count_o, fq.imem_addr_o);
    end
    fq.start_i = 1'b1;
    #1;
    tests_run++;
    if (fq.imem_req_o !== 1'b1 || fq.imem_addr_o !== 32'd12) begin
      fails++;
      $display("FAIL start_resume got r=%b a=%h want 1/0000000c", fq.imem_req_o, fq.imem_addr_o);
    end
    step();
    #1;
    tests_run++;
    if (fq.valid_o !== 1'b1 || fq.pc_o !== 32'd12) begin
      fails++;
      $display("FAIL start_resume_head got v=%b pc=%h want 1/0000000c", fq.valid_o, fq.pc_o);
    end
  endtask

  task automatic test_wrap();
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    fq2.start_i = 1'b1;
    fq2.ready_i = 1'b1;
    #1;
    tests_run++;
    if (fq2.imem_addr_o !== 32'hFFFF_FFF8) begin
      fails++;
      $display("FAIL wrap_reset_pc got %h want fffffff8", fq2.imem_addr_o);
    end
    step();
    #1;
    tests_run++;
    if (fq2.pc_o !== 32'hFFFF_FFF8 || fq2.inst_o !== 32'h5A5A_FFF8) begin
      fails++;
      $display("FAIL wrap_pc0 got pc=%h inst=%h want fffffff8/5a5afff8", fq2.pc_o, fq2.inst_o);
    end
    step();
    #1;
    tests_run++;
    if (fq2.pc_o !== 32'hFFFF_FFFC || fq2.imem_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL wrap_pc1 got pc=%h a=%h want fffffffc/00000000", fq2.pc_o, fq2.imem_addr_o);
    end
    step();
    #1;
    tests_run++;
    if (fq2.pc_o !== 32'h0 || fq2.valid_o !== 1'b1) begin
      fails++;
      $display("FAIL wrap_pc2 got pc=%h v=%b want 00000000/1", fq2.pc_o, fq2.valid_o);
    end
  endtask

  task automatic test_reset_redirect();
    fq.start_i = 1'b1;
    fq.ready_i = 1'b0;
    do_reset();
    repeat (2) step();
    #1;
    tests_run++;
    if (fq.count_o !== 3'd2) begin
      fails++;
      $display("FAIL rr_setup got c=%0d want 2", fq.count_o);
    end
    rst_i            = 1'b1;
    fq.redirect_i    = 1'b1;
    fq.redirect_pc_i = 32'h0000_0500;
    step();
    #1;
    tests_run++;
    if (fq.count_o !== 3'd0 || fq.valid_o !== 1'b0 || fq.imem_addr_o !== RESET_PC_C) begin
      fails++;
      $display("FAIL rr_reset_wins got c=%0d v=%b a=%h want 0/0/%h",
               fq.count_o, fq.valid_o, fq.imem_addr_o, RESET_PC_C);
    end
    rst_i         = 1'b0;
    fq.redirect_i = 1'b0;
    step();
  endtask

  initial begin
    fq.start_i        = 1'b0;
    fq.ready_i        = 1'b0;
    fq.redirect_i     = 1'b0;
    fq.redirect_pc_i  = 32'h0;
    fq2.start_i       = 1'b0;
    fq2.ready_i       = 1'b0;
    fq2.redirect_i    = 1'b0;
    fq2.redirect_pc_i = 32'h0;

    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_start_drop();
    test_wrap();
    test_reset_redirect();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
